capture_scheduler: RTL and testbench
====================================

# capture_scheduler

- Sequences the 16×16 RGB window sampler that sits between the camera pixel stream and the double-buffered picture store.
- Picks the sampled pixels from a configurable window grid and emits a one-pulse-per-sample take strobe with aligned RGB.
- Guarantees exactly 256 takes per captured frame.
- Arbitrates the downstream tracker's fetch request against the store's fetch-ready flag.

## Interface
Parameters:
- IMG_W, 800, active frame width in pixels
- IMG_H, 600, active frame height in lines
- WIN, 16, samples per window row/column (fixed 16 in this design)

Ports:
- i_clk  in  1  clock (one clock, all logic)
- i_rst  in  1  reset, asynchronous, active-high
- i_frame_start  in  1  pulse coincident with pixel (0,0)
- i_pix_valid  in  1  pixel qualifier
- i_x / i_y  in  12 each  pixel coordinates
- i_R / i_G / i_B  in  10 each  pixel colour
- i_win_x0 / i_win_y0  in  12 each  window origin
- i_step  in  4  sample spacing in pixels; 0 treated as 1
- i_buf_ok  in  1  store holds a full buffer
- i_req  in  1  tracker fetch request, level
- o_take  out  1  sample strobe to the store
- o_R / o_G / o_B  out  10 each  colour aligned with o_take
- o_fetch  out  1  fetch pulse to the store
- o_grant  out  1  grant pulse to the tracker
- o_busy  out  1  capture or pad in progress
- o_frame_cnt  out  8  completed captures, wraps at 255
- o_drop_cnt  out  8  padded (incomplete) captures, saturates at 255

## Operation
Capture FSM: S_ARM, S_CAPTURE, S_PAD.
- S_ARM: on i_frame_start, latch i_win_x0, i_win_y0 and step into shadow registers, clear row/col counters, go to S_CAPTURE. Config changes mid-frame have no effect.
- Clamp on latch, 12-bit unsigned:
  - x0 = min(i_win_x0, IMG_W-1-15*step)
  - y0 = min(i_win_y0, IMG_H-1-15*step)
- S_CAPTURE: a pixel is sampled when i_pix_valid=1, i_x == x0+col*step and i_y == y0+row*step.
  - Each sample advances col; col 15→0 advances row.
  - After sample (15,15): o_frame_cnt+1, go to S_ARM.
- S_PAD: entered when i_frame_start arrives in S_CAPTURE before 256 samples.
  - Emit one o_take per cycle with RGB=0 until the total reaches 256. This keeps the store's counters aligned.
  - Then o_drop_cnt+1 and go to S_ARM. The frame whose start caused the pad is not captured.
  - i_frame_start during S_PAD is ignored.

Fetch FSM: F_IDLE, F_HOLD.
- F_IDLE: if i_req=1 and i_buf_ok=1, pulse o_fetch and o_grant for one cycle, go to F_HOLD.
- F_HOLD: wait for i_req=0, then go to F_IDLE. One grant per request.
- The fetch FSM runs independently of the capture FSM; both may be active in the same cycle.

## Timing
- Reset: both FSMs to S_ARM / F_IDLE, counters to 0. All outputs 0: o_take, o_R/G/B, o_fetch, o_grant, o_busy, o_frame_cnt, o_drop_cnt.
- Reset mid-capture: abort immediately. No pad is emitted; the store is reset alongside.
- o_take and o_R/G/B are registered: asserted one cycle after the matching input pixel.
- o_busy is 1 in S_CAPTURE and S_PAD, registered with the state.
- Pad takes are back-to-back, one per cycle; 256−n cycles after entering S_PAD with n samples taken.
- o_fetch and o_grant are asserted one cycle after the cycle where i_req and i_buf_ok are both 1.
- If i_frame_start and the 256th sample occur in the same cycle: complete normally (no pad), then go to S_ARM. That start pulse is not used.

## Configuration
- CAPTURE_DECIMATE_EN defined:
  - Adds input i_skip [3:0].
  - S_ARM captures only one frame in every i_skip+1; skipped frame starts just decrement an internal frame-skip counter.
  - i_skip is sampled at each capture start.
- Not defined: every frame start in S_ARM begins a capture; no i_skip port.

## Test plan
- Window at i_win_x0=100, i_win_y0=50, step=2, full frame → 256 o_take, first at pixel (100,50), last at (130,80); o_frame_cnt=1.
- i_win_x0=795, step=4 → x0 clamps to 739; first take at x=739.
- Frame restart after 100 samples → 156 consecutive pad takes with RGB=0; o_drop_cnt=1; next frame captured fully.
- i_req=1 with i_buf_ok=0 for 20 cycles, then i_buf_ok=1 → exactly one o_fetch/o_grant pulse one cycle later. No second pulse while i_req stays high.
- i_rst asserted mid-capture (sample 37) → all outputs 0 next edge; capture restarts at the next i_frame_start.
- With CAPTURE_DECIMATE_EN and i_skip=2 over 9 frames → 3 captures, o_frame_cnt=3.

Source files
------------

// File: rtl/capture_scheduler_if.sv
// capture_scheduler_if: groups the camera pixel stream, window configuration,
// tracker/store fetch handshake and the capture outputs of capture_scheduler.
// The i_skip input exists only when CAPTURE_DECIMATE_EN is defined.
interface capture_scheduler_if;
    logic        i_frame_start;
    logic        i_pix_valid;
    logic [11:0] i_x;
    logic [11:0] i_y;
    logic [9:0]  i_R;
    logic [9:0]  i_G;
    logic [9:0]  i_B;
    logic [11:0] i_win_x0;
    logic [11:0] i_win_y0;
    logic [3:0]  i_step;
    logic        i_buf_ok;
    logic        i_req;
`ifdef CAPTURE_DECIMATE_EN
    logic [3:0]  i_skip;
`endif
    logic        o_take;
    logic [9:0]  o_R;
    logic [9:0]  o_G;
    logic [9:0]  o_B;
    logic        o_fetch;
    logic        o_grant;
    logic        o_busy;
    logic [7:0]  o_frame_cnt;
    logic [7:0]  o_drop_cnt;

    // Source side: camera, configuration and tracker drive the inputs.
    modport master (
`ifdef CAPTURE_DECIMATE_EN
        output i_skip,
`endif
        output i_frame_start, i_pix_valid, i_x, i_y, i_R, i_G, i_B,
        output i_win_x0, i_win_y0, i_step, i_buf_ok, i_req,
        input  o_take, o_R, o_G, o_B, o_fetch, o_grant, o_busy,
        input  o_frame_cnt, o_drop_cnt
    );

    // Scheduler side.
    modport slave (
`ifdef CAPTURE_DECIMATE_EN
        input  i_skip,
`endif
        input  i_frame_start, i_pix_valid, i_x, i_y, i_R, i_G, i_B,
        input  i_win_x0, i_win_y0, i_step, i_buf_ok, i_req,
        output o_take, o_R, o_G, o_B, o_fetch, o_grant, o_busy,
        output o_frame_cnt, o_drop_cnt
    );
endinterface

// File: rtl/capture_scheduler.sv
// capture_scheduler: samples a 16x16 window grid out of the camera pixel
// stream, guarantees 256 takes per capture (padding with black when a frame
// restarts early) and arbitrates tracker fetch requests against the store.
// Optional feature macro: CAPTURE_DECIMATE_EN (adds i_skip frame decimation).
module capture_scheduler #(
    parameter int IMG_W = 800,
    parameter int IMG_H = 600,
    parameter int WIN   = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    capture_scheduler_if.slave  bus
);

    localparam logic [1:0] S_ARM     = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_PAD     = 2'd2;

    localparam logic [0:0] F_IDLE = 1'b0;
    localparam logic [0:0] F_HOLD = 1'b1;

    localparam logic [7:0]  IDX_LAST = 8'(WIN * WIN - 1);
    localparam logic [11:0] X_MAX    = 12'(IMG_W - 1);
    localparam logic [11:0] Y_MAX    = 12'(IMG_H - 1);

    // Capture state; idx counts samples taken: [3:0] = col, [7:4] = row.
    logic [1:0]  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [11:0] x0_q, x0_d;
    logic [11:0] y0_q, y0_d;
    logic [3:0]  step_q, step_d;
    logic        take_q, take_d;
    logic [9:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic        busy_q, busy_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
`ifdef CAPTURE_DECIMATE_EN
    logic [3:0]  skip_q, skip_d;
`endif

    // Fetch arbitration state.
    logic [0:0]  fstate_q, fstate_d;
    logic        fetch_q, fetch_d;

    // Window geometry derived from the live config, used only at capture start.
    logic [3:0]  step_eff;
    logic [11:0] span;
    logic [11:0] lim_x, lim_y;
    logic [11:0] clamp_x, clamp_y;
    logic        arm_start;
    logic        arm_hit;

    // Target pixel of the next sample inside the current capture.
    logic [11:0] tgt_x, tgt_y;
    logic        cap_hit;

    assign step_eff = (bus.i_step == 4'd0) ? 4'd1 : bus.i_step;
    assign span     = 12'(WIN - 1) * {8'd0, step_eff};
    assign lim_x    = X_MAX - span;
    assign lim_y    = Y_MAX - span;
    assign clamp_x  = (bus.i_win_x0 > lim_x) ? lim_x : bus.i_win_x0;
    assign clamp_y  = (bus.i_win_y0 > lim_y) ? lim_y : bus.i_win_y0;

    // Pixel (0,0) arrives with the start pulse, so the first grid point may
    // coincide with it when the window sits at the origin.
    assign arm_hit = bus.i_pix_valid && (bus.i_x == clamp_x) && (bus.i_y == clamp_y);

`ifdef CAPTURE_DECIMATE_EN
    assign arm_start = bus.i_frame_start && (skip_q == 4'd0);
`else
    assign arm_start = bus.i_frame_start;
`endif

    assign tgt_x   = x0_q + ({8'd0, idx_q[3:0]} * {8'd0, step_q});
    assign tgt_y   = y0_q + ({8'd0, idx_q[7:4]} * {8'd0, step_q});
    assign cap_hit = (state_q == S_CAPTURE) && bus.i_pix_valid &&
                     (bus.i_x == tgt_x) && (bus.i_y == tgt_y);

    // Capture FSM next-state, sample strobe and counters.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        step_d      = step_q;
        take_d      = 1'b0;
        r_d         = 10'd0;
        g_d         = 10'd0;
        b_d         = 10'd0;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
`ifdef CAPTURE_DECIMATE_EN
        skip_d      = skip_q;
`endif
        case (state_q)
            S_ARM: begin
`ifdef CAPTURE_DECIMATE_EN
                if (bus.i_frame_start) begin
                    skip_d = (skip_q == 4'd0) ? bus.i_skip : skip_q - 4'd1;
                end
`endif
                if (arm_start) begin
                    x0_d    = clamp_x;
                    y0_d    = clamp_y;
                    step_d  = step_eff;
                    idx_d   = 8'd0;
                    state_d = S_CAPTURE;
                    if (arm_hit) begin
                        take_d = 1'b1;
                        r_d    = bus.i_R;
                        g_d    = bus.i_G;
                        b_d    = bus.i_B;
                        idx_d  = 8'd1;
                    end
                end
            end
            S_CAPTURE: begin
                if (cap_hit && idx_q == IDX_LAST) begin
                    // The final sample wins over a coincident start pulse.
                    take_d      = 1'b1;
                    r_d         = bus.i_R;
                    g_d         = bus.i_G;
                    b_d         = bus.i_B;
                    idx_d       = 8'd0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = S_ARM;
                end else if (bus.i_frame_start) begin
                    state_d = S_PAD;
                end else if (cap_hit) begin
                    take_d = 1'b1;
                    r_d    = bus.i_R;
                    g_d    = bus.i_G;
                    b_d    = bus.i_B;
                    idx_d  = idx_q + 8'd1;
                end
            end
            S_PAD: begin
                // Black takes back-to-back until the store has seen 256.
                take_d = 1'b1;
                if (idx_q == IDX_LAST) begin
                    idx_d   = 8'd0;
                    state_d = S_ARM;
                    if (drop_cnt_q != 8'hFF) begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            default: begin
                state_d = S_ARM;
                idx_d   = 8'd0;
            end
        endcase
    end

    assign busy_d = (state_d != S_ARM);

    // Capture registers; reset aborts any capture without padding.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_ARM;
            idx_q       <= 8'd0;
            x0_q        <= 12'd0;
            y0_q        <= 12'd0;
            step_q      <= 4'd1;
            take_q      <= 1'b0;
            r_q         <= 10'd0;
            g_q         <= 10'd0;
            b_q         <= 10'd0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
            drop_cnt_q  <= 8'd0;
`ifdef CAPTURE_DECIMATE_EN
            skip_q      <= 4'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            step_q      <= step_d;
            take_q      <= take_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
`ifdef CAPTURE_DECIMATE_EN
            skip_q      <= skip_d;
`endif
        end
    end

    // Fetch FSM: one grant per request level, only while the store is full.
    always_comb begin
        fstate_d = fstate_q;
        fetch_d  = 1'b0;
        case (fstate_q)
            F_IDLE: begin
                if (bus.i_req && bus.i_buf_ok) begin
                    fetch_d  = 1'b1;
                    fstate_d = F_HOLD;
                end
            end
            F_HOLD: begin
                if (!bus.i_req) begin
                    fstate_d = F_IDLE;
                end
            end
            default: fstate_d = F_IDLE;
        endcase
    end

    // Fetch registers; fetch and grant are the same pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fstate_q <= F_IDLE;
            fetch_q  <= 1'b0;
        end else begin
            fstate_q <= fstate_d;
            fetch_q  <= fetch_d;
        end
    end

    assign bus.o_take      = take_q;
    assign bus.o_R         = r_q;
    assign bus.o_G         = g_q;
    assign bus.o_B         = b_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_frame_cnt = frame_cnt_q;
    assign bus.o_drop_cnt  = drop_cnt_q;
    assign bus.o_fetch     = fetch_q;
    assign bus.o_grant     = fetch_q;

endmodule

// File: tb/tb_capture_scheduler.sv
// tb_capture_scheduler: directed self-checking bench for capture_scheduler.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same
// point, so each observed take belongs to the pixel driven one cycle earlier.
// Decimation cases run only when CAPTURE_DECIMATE_EN is defined.
module tb_capture_scheduler;

    logic i_clk;
    logic i_rst;

    capture_scheduler_if bus();

    capture_scheduler #(
        .IMG_W (800),
        .IMG_H (600),
        .WIN   (16)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          takes    = 0;
    int          rgb_bad  = 0;
    int          fetches  = 0;
    int          first_cyc, last_cyc, c0;
    logic [11:0] first_x, first_y, last_x, last_y;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One pixel cycle; records any take produced by this pixel.
    task automatic drive(input logic fs, input logic valid, input logic [11:0] x, input logic [11:0] y);
        logic [9:0] er, eg, eb;
        er = valid ? x[9:0] : 10'd0;
        eg = valid ? y[9:0] : 10'd0;
        eb = valid ? (x[9:0] ^ y[9:0]) : 10'd0;
        bus.i_frame_start = fs;
        bus.i_pix_valid   = valid;
        bus.i_x           = x;
        bus.i_y           = y;
        bus.i_R           = er;
        bus.i_G           = eg;
        bus.i_B           = eb;
        @(posedge i_clk);
        #1;
        cyc++;
        if (bus.o_take) begin
            takes++;
            if (takes == 1) begin
                first_x   = x;
                first_y   = y;
                first_cyc = cyc;
            end
            last_x   = x;
            last_y   = y;
            last_cyc = cyc;
            if (bus.o_R != er || bus.o_G != eg || bus.o_B != eb) rgb_bad++;
        end
        if (bus.o_fetch) fetches++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 12'd0, 12'd0);
    endtask

    task automatic set_win(input logic [11:0] x0, input logic [11:0] y0, input logic [3:0] step);
        bus.i_win_x0 = x0;
        bus.i_win_y0 = y0;
        bus.i_step   = step;
    endtask

    // Start pulse on pixel (0,0), then a raster sweep of the given rectangle.
    task automatic send_frame(input int x_lo, input int x_hi, input int y_lo, input int y_hi,
                              input logic fs_last, input int stop_at);
        takes   = 0;
        rgb_bad = 0;
        drive(1'b1, 1'b1, 12'd0, 12'd0);
        for (int y = y_lo; y <= y_hi; y++) begin
            for (int x = x_lo; x <= x_hi; x++) begin
                if (stop_at == 0 || takes < stop_at) begin
                    drive(fs_last && (x == x_hi) && (y == y_hi), 1'b1, 12'(x), 12'(y));
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " take"},  32'(bus.o_take),      32'd0);
        check({tag, " rgb"},   32'({bus.o_R, bus.o_G, bus.o_B}), 32'd0);
        check({tag, " fetch"}, 32'(bus.o_fetch),     32'd0);
        check({tag, " grant"}, 32'(bus.o_grant),     32'd0);
        check({tag, " busy"},  32'(bus.o_busy),      32'd0);
        check({tag, " fcnt"},  32'(bus.o_frame_cnt), 32'd0);
        check({tag, " dcnt"},  32'(bus.o_drop_cnt),  32'd0);
    endtask

    initial begin
        i_rst             = 1'b1;
        bus.i_frame_start = 1'b0;
        bus.i_pix_valid   = 1'b0;
        bus.i_x           = 12'd0;
        bus.i_y           = 12'd0;
        bus.i_R           = 10'd0;
        bus.i_G           = 10'd0;
        bus.i_B           = 10'd0;
        bus.i_buf_ok      = 1'b0;
        bus.i_req         = 1'b0;
        set_win(12'd100, 12'd50, 4'd2);
`ifdef CAPTURE_DECIMATE_EN
        bus.i_skip        = 4'd0;
`endif
        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        i_rst = 1'b0;
        idle(2);

        // Nominal window 100,50 step 2: grid spans (100,50)..(130,80).
        send_frame(100, 130, 50, 80, 1'b0, 0);
        check("win takes",   32'(takes),   32'd256);
        check("win first x", 32'(first_x), 32'd100);
        check("win first y", 32'(first_y), 32'd50);
        check("win last x",  32'(last_x),  32'd130);
        check("win last y",  32'(last_y),  32'd80);
        check("win rgb",     32'(rgb_bad), 32'd0);
        check("win fcnt",    32'(bus.o_frame_cnt), 32'd1);
        check("win busy",    32'(bus.o_busy), 32'd0);
        idle(2);

        // x0=795 step 4 clamps to 799-60 = 739; last column 799, rows 10..70.
        set_win(12'd795, 12'd10, 4'd4);
        send_frame(739, 799, 10, 70, 1'b0, 0);
        check("clamp takes",   32'(takes),   32'd256);
        check("clamp first x", 32'(first_x), 32'd739);
        check("clamp first y", 32'(first_y), 32'd10);
        check("clamp last x",  32'(last_x),  32'd799);
        check("clamp last y",  32'(last_y),  32'd70);
        check("clamp fcnt",    32'(bus.o_frame_cnt), 32'd2);
        idle(2);

        // Restart after 100 samples: 156 black takes starting one cycle later.
        set_win(12'd100, 12'd50, 4'd2);
        send_frame(100, 130, 50, 80, 1'b0, 100);
        check("pre-pad takes", 32'(takes), 32'd100);
        check("pre-pad busy",  32'(bus.o_busy), 32'd1);
        takes   = 0;
        rgb_bad = 0;
        drive(1'b1, 1'b1, 12'd0, 12'd0);
        c0 = cyc;
        idle(200);
        check("pad takes",   32'(takes), 32'd156);
        check("pad run",     32'(last_cyc - first_cyc + 1), 32'd156);
        check("pad latency", 32'(first_cyc - c0), 32'd1);
        check("pad rgb",     32'(rgb_bad), 32'd0);
        check("pad dcnt",    32'(bus.o_drop_cnt), 32'd1);
        check("pad fcnt",    32'(bus.o_frame_cnt), 32'd2);
        check("pad busy",    32'(bus.o_busy), 32'd0);
        send_frame(100, 130, 50, 80, 1'b0, 0);
        check("post-pad takes", 32'(takes), 32'd256);
        check("post-pad fcnt",  32'(bus.o_frame_cnt), 32'd3);
        idle(2);

        // Fetch: held off while the store is not full, then a single pulse.
        fetches      = 0;
        bus.i_req    = 1'b1;
        bus.i_buf_ok = 1'b0;
        idle(20);
        check("fetch blocked", 32'(fetches), 32'd0);
        bus.i_buf_ok = 1'b1;
        idle(1);
        check("fetch pulse", 32'(bus.o_fetch), 32'd1);
        check("grant pulse", 32'(bus.o_grant), 32'd1);
        fetches = 0;
        idle(10);
        check("fetch once", 32'(fetches), 32'd0);
        bus.i_req = 1'b0;
        idle(1);
        bus.i_req = 1'b1;
        idle(1);
        check("fetch rearm", 32'(bus.o_grant), 32'd1);
        bus.i_req    = 1'b0;
        bus.i_buf_ok = 1'b0;
        idle(2);

        // Reset at sample 37 clears everything; capture waits for a new start.
        send_frame(100, 130, 50, 80, 1'b0, 37);
        check("rst takes", 32'(takes), 32'd37);
        check("rst take",  32'(bus.o_take), 32'd1);
        check("rst busy",  32'(bus.o_busy), 32'd1);
        #2;
        i_rst = 1'b1;
        #1;
        check("rst async take", 32'(bus.o_take), 32'd0);
        idle(1);
        check_all_zero("mid rst");
        i_rst = 1'b0;
        takes = 0;
        drive(1'b0, 1'b1, 12'd100, 12'd50);
        idle(1);
        check("rst no start", 32'(takes), 32'd0);
        send_frame(100, 130, 50, 80, 1'b0, 0);
        check("rst recap takes", 32'(takes), 32'd256);
        check("rst recap fcnt",  32'(bus.o_frame_cnt), 32'd1);
        idle(2);

        // Step 0 acts as 1 at the origin; start coincides with the 256th sample.
        set_win(12'd0, 12'd0, 4'd0);
        send_frame(0, 15, 0, 15, 1'b1, 0);
        check("org takes",   32'(takes),   32'd256);
        check("org first x", 32'(first_x), 32'd0);
        check("org first y", 32'(first_y), 32'd0);
        check("org last x",  32'(last_x),  32'd15);
        check("org last y",  32'(last_y),  32'd15);
        check("org fcnt",    32'(bus.o_frame_cnt), 32'd2);
        check("org dcnt",    32'(bus.o_drop_cnt),  32'd0);
        takes = 0;
        drive(1'b0, 1'b1, 12'd0, 12'd0);
        idle(3);
        check("org no pad",  32'(takes), 32'd0);
        check("org idle",    32'(bus.o_busy), 32'd0);

`ifdef CAPTURE_DECIMATE_EN
        // i_skip=2: frames 0, 3 and 6 of nine are captured.
        set_win(12'd100, 12'd50, 4'd2);
        bus.i_skip = 4'd2;
        for (int f = 0; f < 9; f++) begin
            send_frame(100, 130, 50, 80, 1'b0, 0);
            check($sformatf("dec f%0d takes", f), 32'(takes), (f % 3 == 0) ? 32'd256 : 32'd0);
        end
        check("dec fcnt", 32'(bus.o_frame_cnt), 32'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
